// File: rtl/osc_pkg.sv
// Shared constants and types for the oscilloscope waveform capture path.
package osc_pkg;

   localparam int SAMPLE_W  = 12;
   localparam int FRAME_LEN = 256;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } wave_wr_state_t;

endpackage

// File: rtl/wave_bank_ram.sv
// Simple dual-port RAM holding both frame banks; the address MSB selects the bank.
module wave_bank_ram #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: no reset on the array or read register so this maps onto block RAM;
   // stale contents are hidden by the valid flag in the parent.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wave_frame_buffer.sv
// Double-buffered waveform frame store: a capture FSM fills the hidden bank while
// the renderer reads the displayed one; banks swap on vsync once a frame is complete.
module wave_frame_buffer #(
   parameter  int SAMPLE_W  = osc_pkg::SAMPLE_W,
   parameter  int FRAME_LEN = osc_pkg::FRAME_LEN,
   localparam int AW        = $clog2(FRAME_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   input  logic [SAMPLE_W-1:0] wr_data,
   input  logic                wr_first,
   input  logic                wr_abort,
   input  logic                vsync,
   input  logic [AW-1:0]       rd_addr,
   output logic [SAMPLE_W-1:0] rd_data,
   output logic                rd_valid,
   output logic [7:0]          frame_count,
   output logic                overrun
);

   import osc_pkg::*;

   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

   wave_wr_state_t      state_q;
   logic [AW-1:0]       wr_ptr_q;
   logic                disp_bank_q;
   logic                rd_valid_q;
   logic                overrun_q;
   logic [7:0]          frame_count_q;

   logic                wr_start;
   logic                ram_we;
   logic [AW:0]         ram_waddr;
   logic [SAMPLE_W-1:0] ram_rdata;

   assign wr_start = wr_valid && wr_first;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = {~disp_bank_q, wr_ptr_q};
      case (state_q)
         IDLE: begin
            if (wr_start) begin
               ram_we    = 1'b1;
               ram_waddr = {~disp_bank_q, {AW{1'b0}}};
            end
         end
         FILL: begin
            if (!wr_abort && wr_valid) begin
               ram_we    = 1'b1;
               ram_waddr = {~disp_bank_q, (wr_first ? {AW{1'b0}} : wr_ptr_q)};
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         disp_bank_q   <= 1'b0;
         rd_valid_q    <= 1'b0;
         overrun_q     <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (wr_start) begin
                  wr_ptr_q <= AW'(1);
                  state_q  <= FILL;
               end
            end
            FILL: begin
               // Abort wins over a restart or a plain sample in the same cycle.
               if (wr_abort) begin
                  state_q <= IDLE;
               end else if (wr_start) begin
                  wr_ptr_q <= AW'(1);
               end else if (wr_valid) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  if (wr_ptr_q == LAST_ADDR) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               if (wr_start) begin
                  overrun_q <= 1'b1;
               end
               if (vsync) begin
                  disp_bank_q   <= ~disp_bank_q;
                  rd_valid_q    <= 1'b1;
                  frame_count_q <= frame_count_q + 8'd1;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   wave_bank_ram #(
      .DATA_W (SAMPLE_W),
      .ADDR_W (AW + 1)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (wr_data),
      .raddr_i ({disp_bank_q, rd_addr}),
      .rdata_o (ram_rdata)
   );

   // Uninitialised or stale RAM is never visible until a complete frame is shown.
   assign rd_data     = rd_valid_q ? ram_rdata : '0;
   assign rd_valid    = rd_valid_q;
   assign frame_count = frame_count_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_wave_frame_buffer.sv
// Directed bench for wave_frame_buffer: stimulus pushes expectations into queues,
// a monitor on the falling edge pops and compares them against the DUT.
module tb_wave_frame_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic [11:0] wr_data = '0;
   logic        wr_first = 1'b0;
   logic        wr_abort = 1'b0;
   logic        vsync = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic [11:0] rd_data;
   logic        rd_valid;
   logic [7:0]  frame_count;
   logic        overrun;

   typedef enum {F_VALID, F_COUNT, F_OVR, F_RDATA} field_e;
   typedef struct {string name; field_e f; logic [31:0] exp;} st_t;
   typedef struct {string name; logic [31:0] exp;} rd_t;

   st_t st_q[$];
   rd_t rd_q[$];
   logic rd_issue = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   wave_frame_buffer dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_first    (wr_first),
      .wr_abort    (wr_abort),
      .vsync       (vsync),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .frame_count (frame_count),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: a read issued this cycle is compared at the next falling edge;
   // status expectations are compared at the falling edge of the cycle they were pushed.
   initial begin
      logic rd_pend;
      rd_t  r;
      st_t  s;
      rd_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_pend && rd_q.size() > 0) begin
            r = rd_q.pop_front();
            check(r.name, 32'(rd_data), r.exp);
         end
         rd_pend = rd_issue;
         while (st_q.size() > 0) begin
            s = st_q.pop_front();
            case (s.f)
               F_VALID: check(s.name, 32'(rd_valid), s.exp);
               F_COUNT: check(s.name, 32'(frame_count), s.exp);
               F_OVR:   check(s.name, 32'(overrun), s.exp);
               default: check(s.name, 32'(rd_data), s.exp);
            endcase
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input field_e f, input logic [31:0] exp, input string name);
      st_q.push_back('{name, f, exp});
   endtask

   task automatic rd(input logic [7:0] a, input logic [11:0] exp, input string name,
                     input bit vs = 1'b0);
      rd_addr  = a;
      vsync    = vs;
      rd_issue = 1'b1;
      rd_q.push_back('{name, 32'(exp)});
      step();
      rd_issue = 1'b0;
      vsync    = 1'b0;
   endtask

   task automatic write_sample(input logic [11:0] d, input bit first, input bit vs = 1'b0);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_first = first;
      vsync    = vs;
      step();
      wr_valid = 1'b0;
      wr_first = 1'b0;
      vsync    = 1'b0;
   endtask

   task automatic write_frame(input logic [11:0] base, input int n, input bit vs_last = 1'b0);
      for (int i = 0; i < n; i++)
         write_sample(base + 12'(i), i == 0, vs_last && (i == n - 1));
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      step();
      vsync = 1'b0;
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      step();
      expect_st(F_VALID, 0, "reset rd_valid");
      expect_st(F_COUNT, 0, "reset frame_count");
      expect_st(F_OVR,   0, "reset overrun");
      expect_st(F_RDATA, 0, "reset rd_data");
      rd(8'd3, 12'h000, "read masked before first frame");

      // Fill and swap: data = index.
      write_frame(12'h000, 256);
      expect_st(F_VALID, 0, "rd_valid before vsync");
      pulse_vsync();
      expect_st(F_VALID, 1, "fill rd_valid");
      expect_st(F_COUNT, 1, "fill frame_count");
      rd(8'd37,  12'd37,  "fill read 37");
      rd(8'd0,   12'd0,   "fill read 0");
      rd(8'd255, 12'd255, "fill read 255");
      pulse_vsync();
      expect_st(F_COUNT, 1, "vsync in IDLE ignored");

      // Abort a partial frame, then a full 0xA00+i frame.
      write_frame(12'h300, 100);
      wr_abort = 1'b1;
      step();
      wr_abort = 1'b0;
      pulse_vsync();
      expect_st(F_COUNT, 1, "no swap after abort");
      write_frame(12'hA00, 256);
      pulse_vsync();
      expect_st(F_COUNT, 2, "abort frame_count");
      rd(8'd5,   12'hA05, "abort read 5");
      rd(8'd99,  12'hA63, "abort read 99");
      rd(8'd100, 12'hA64, "abort read 100");

      // Overrun: complete frame left unswapped, then a new wr_first.
      write_frame(12'h400, 256);
      write_sample(12'h7FF, 1'b1);
      write_sample(12'h7EE, 1'b0);
      expect_st(F_OVR,   1, "overrun set");
      expect_st(F_COUNT, 2, "overrun no swap");
      rd(8'd5, 12'hA05, "overrun display unchanged");
      pulse_vsync();
      expect_st(F_COUNT, 3, "overrun swap count");
      rd(8'd5, 12'h405, "overrun swapped read 5");
      rd(8'd0, 12'h400, "overrun read 0 untouched");
      rd(8'd1, 12'h401, "overrun read 1 untouched");

      // Boundary: vsync with the final write does not swap.
      write_frame(12'h600, 256, 1'b1);
      expect_st(F_COUNT, 3, "boundary no swap");
      rd(8'd10, 12'h40A, "boundary pre-swap read");
      rd(8'd10, 12'h40A, "boundary swap-cycle read old", 1'b1);
      rd(8'd10, 12'h60A, "boundary post-swap read new");
      expect_st(F_COUNT, 4, "boundary frame_count");

      // Wrap: 252 more swaps brings the count to 256 mod 256.
      for (int k = 1; k <= 252; k++) begin
         write_frame(12'h000, 256);
         pulse_vsync();
         if (k == 251) expect_st(F_COUNT, 255, "wrap count 255");
      end
      expect_st(F_COUNT, 0, "wrap count 0");
      expect_st(F_VALID, 1, "wrap rd_valid");

      // Reset in the middle of a fill.
      write_frame(12'h900, 50);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_st(F_VALID, 0, "rst rd_valid");
      expect_st(F_COUNT, 0, "rst frame_count");
      expect_st(F_OVR,   0, "rst overrun");
      expect_st(F_RDATA, 0, "rst rd_data");
      rd(8'd5, 12'h000, "rst read masked");
      write_frame(12'h800, 256);
      pulse_vsync();
      expect_st(F_VALID, 1, "post-rst rd_valid");
      expect_st(F_COUNT, 1, "post-rst frame_count");
      rd(8'd200, 12'h8C8, "post-rst read 200");

      for (int k = 0; k < 10 && (rd_q.size() != 0 || st_q.size() != 0); k++)
         @(negedge clk);
      @(negedge clk);
      check("queues drained", 32'(rd_q.size() + st_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
